// File: rtl/aud_bus_pkg.sv
// rtl/aud_bus_pkg.sv - shared widths and FSM state type for the audio write arbiter
package aud_bus_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or after start
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(start) + k) % NREQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/aud_wr_arbiter.sv
// rtl/aud_wr_arbiter.sv - round-robin sharing of one AW/W/B write port among NREQ requesters
// Optional per-transaction timeout with err pulse: define AUD_WR_TIMEOUT_EN.
module aud_wr_arbiter
  import aud_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      AWADDR,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [DATA_W-1:0]      WDATA,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic                   BVALID,
  output logic                   BREADY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state, state_n;
  logic [NREQ-1:0]    gnt_n, done_n;
  logic [ADDR_W-1:0]  awaddr_n, addr_sel;
  logic [DATA_W-1:0]  wdata_n, data_sel;
  logic               awvalid_n, wvalid_n, bready_n;
  logic [IDX_W-1:0]   win_idx, win_idx_n, last_winner, last_n, start;
  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  assign start = (last_winner == IDX_W'(NREQ - 1)) ? '0 : last_winner + 1'b1;
  assign busy  = (state != IDLE);

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .start      (start),
    .winner     (arb_gnt),
    .winner_idx (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef AUD_WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NREQ-1:0]  err_q, err_n;
  assign err = err_q;
`else
  // err is constant 0; TIMEOUT only matters when the counter is built in
  assign err = {NREQ{TIMEOUT < 0}};
`endif

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    done_n    = '0;
    awaddr_n  = AWADDR;
    wdata_n   = WDATA;
    awvalid_n = AWVALID;
    wvalid_n  = WVALID;
    bready_n  = BREADY;
    win_idx_n = win_idx;
    last_n    = last_winner;
`ifdef AUD_WR_TIMEOUT_EN
    err_n     = '0;
    cnt_n     = cnt;
`endif
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_n   = XFER;
          gnt_n     = arb_gnt;
          win_idx_n = arb_idx;
          awaddr_n  = addr_sel;
          wdata_n   = data_sel;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
`ifdef AUD_WR_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end
      XFER: begin
        // AW and W retire independently; B is only accepted once both have
        if (AWVALID && AWREADY) awvalid_n = 1'b0;
        if (WVALID && WREADY)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = RESP;
        end
      end
      RESP: begin
        if (BVALID && BREADY) begin
          bready_n = 1'b0;
          gnt_n    = '0;
          done_n   = gnt;
          last_n   = win_idx;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef AUD_WR_TIMEOUT_EN
    // a B handshake landing on the expiry cycle wins over the timeout
    if (state != IDLE && state_n != IDLE) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        bready_n  = 1'b0;
        gnt_n     = '0;
        err_n     = gnt;
        last_n    = win_idx;
        state_n   = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      AWADDR      <= '0;
      WDATA       <= '0;
      AWVALID     <= 1'b0;
      WVALID      <= 1'b0;
      BREADY      <= 1'b0;
      win_idx     <= '0;
      last_winner <= IDX_W'(NREQ - 1);
`ifdef AUD_WR_TIMEOUT_EN
      err_q       <= '0;
      cnt         <= '0;
`endif
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      done        <= done_n;
      AWADDR      <= awaddr_n;
      WDATA       <= wdata_n;
      AWVALID     <= awvalid_n;
      WVALID      <= wvalid_n;
      BREADY      <= bready_n;
      win_idx     <= win_idx_n;
      last_winner <= last_n;
`ifdef AUD_WR_TIMEOUT_EN
      err_q       <= err_n;
      cnt         <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_aud_wr_arbiter.sv
// tb/tb_aud_wr_arbiter.sv - directed self-checking bench for aud_wr_arbiter
module tb_aud_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [13:0] req_data = '0;
  logic [1:0]  gnt, done, err;
  logic        busy;
  logic [3:0]  AWADDR;
  logic        AWVALID, WVALID, BREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [6:0]  WDATA;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aud_wr_arbiter #(.NREQ(2), .ADDR_W(4), .DATA_W(7), .TIMEOUT(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BVALID   (BVALID),
    .BREADY   (BREADY)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, busy, AWVALID, WVALID, BREADY, AWADDR, WDATA} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {gnt, done, err, busy, AWVALID, WVALID, BREADY, AWADDR, WDATA});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    req_addr = {4'h0, 4'h3};
    req_data = {7'h00, 7'h45};
    AWREADY = 1'b1; WREADY = 1'b1;
    req = 2'b01;
    @(negedge clk);
    checks++;
    if ({gnt, busy, AWVALID, WVALID, AWADDR, WDATA} !== {2'b01, 3'b111, 4'h3, 7'h45}) begin
      errors++;
      $display("FAIL single_issue: got gnt=%b busy=%b awv=%b wv=%b addr=%h data=%h expected 01 1 1 1 3 45",
               gnt, busy, AWVALID, WVALID, AWADDR, WDATA);
    end
    @(negedge clk);
    checks++;
    if ({AWVALID, WVALID, BREADY, done} !== 5'b00100) begin
      errors++;
      $display("FAIL single_resp: got awv=%b wv=%b bready=%b done=%b expected 0 0 1 00",
               AWVALID, WVALID, BREADY, done);
    end
    BVALID = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, BREADY, gnt, busy} !== 6'b010000) begin
      errors++;
      $display("FAIL single_done: got done=%b bready=%b gnt=%b busy=%b expected 01 0 00 0",
               done, BREADY, gnt, busy);
    end
    req = '0; BVALID = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy, gnt, err} !== 7'b0) begin
      errors++;
      $display("FAIL single_after: got done=%b busy=%b gnt=%b err=%b expected all 0",
               done, busy, gnt, err);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, exp_d, who;
    logic [3:0] exp_a;
    do_reset();
    req_addr = {4'h9, 4'h3};
    req_data = {7'h11, 7'h22};
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      who   = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      exp_g = (k % 3 == 2) ? 2'b00 : who;
      exp_d = (k % 3 == 2) ? who : 2'b00;
      exp_a = (who == 2'b01) ? 4'h3 : 4'h9;
      checks++;
      if (gnt !== exp_g || done !== exp_d || (k % 3 == 0 && AWADDR !== exp_a)) begin
        errors++;
        $display("FAIL contention_k%0d: got gnt=%b done=%b addr=%h expected gnt=%b done=%b addr=%h",
                 k, gnt, done, AWADDR, exp_g, exp_d, exp_a);
      end
    end
    req = '0; BVALID = 1'b0;
  endtask

  task automatic test_split_handshake();
    do_reset();
    req_addr = {4'hA, 4'h0};
    req_data = {7'h5A, 7'h00};
    req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, AWVALID, WVALID, BREADY} !== 5'b10110) begin
      errors++;
      $display("FAIL split_wait: got gnt=%b awv=%b wv=%b bready=%b expected 10 1 1 0",
               gnt, AWVALID, WVALID, BREADY);
    end
    WREADY = 1'b1;
    @(negedge clk);
    WREADY = 1'b0;
    checks++;
    if ({AWVALID, WVALID, BREADY, AWADDR} !== {3'b100, 4'hA}) begin
      errors++;
      $display("FAIL split_w_done: got awv=%b wv=%b bready=%b addr=%h expected 1 0 0 a",
               AWVALID, WVALID, BREADY, AWADDR);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({AWVALID, AWADDR, WDATA, BREADY} !== {1'b1, 4'hA, 7'h5A, 1'b0}) begin
      errors++;
      $display("FAIL split_aw_hold: got awv=%b addr=%h data=%h bready=%b expected 1 a 5a 0",
               AWVALID, AWADDR, WDATA, BREADY);
    end
    AWREADY = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0;
    checks++;
    if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
      errors++;
      $display("FAIL split_aw_done: got awv=%b wv=%b bready=%b expected 0 0 1",
               AWVALID, WVALID, BREADY);
    end
    BVALID = 1'b1;
    @(negedge clk);
    BVALID = 1'b0; req = '0;
    checks++;
    if ({done, gnt} !== 4'b1000) begin
      errors++;
      $display("FAIL split_done: got done=%b gnt=%b expected 10 00", done, gnt);
    end
  endtask

  task automatic test_early_bvalid();
    do_reset();
    req_addr = {4'h0, 4'h7};
    req_data = {7'h00, 7'h33};
    WREADY = 1'b1; BVALID = 1'b1;
    req = 2'b01;
    @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if ({AWVALID, WVALID, BREADY, done} !== 5'b10000) begin
      errors++;
      $display("FAIL early_b_ignored: got awv=%b wv=%b bready=%b done=%b expected 1 0 0 00",
               AWVALID, WVALID, BREADY, done);
    end
    BVALID = 1'b0; AWREADY = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0;
    @(negedge clk);
    checks++;
    if ({BREADY, done} !== 3'b100) begin
      errors++;
      $display("FAIL early_b_wait: got bready=%b done=%b expected 1 00", BREADY, done);
    end
    BVALID = 1'b1;
    @(negedge clk);
    BVALID = 1'b0; req = '0;
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL early_b_done: got done=%b expected 01", done);
    end
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    req_addr = {4'h5, 4'h1};
    req_data = {7'h0F, 7'h70};
    AWREADY = 1'b1; WREADY = 1'b1;
    req = 2'b01;
    repeat (2) @(negedge clk);
    checks++;
    if (BREADY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got bready=%b expected 1", BREADY);
    end
    #1 reset = 1'b1;
    BVALID = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, busy, AWVALID, WVALID, BREADY, AWADDR, WDATA} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {gnt, done, err, busy, AWVALID, WVALID, BREADY, AWADDR, WDATA});
    end
    @(negedge clk);
    reset = 1'b0; BVALID = 1'b0;
    req = 2'b10;
    @(negedge clk);
    checks++;
    if ({gnt, done, AWADDR} !== {2'b10, 2'b00, 4'h5}) begin
      errors++;
      $display("FAIL rst_mid_next: got gnt=%b done=%b addr=%h expected 10 00 5", gnt, done, AWADDR);
    end
    req = '0;
  endtask

`ifdef AUD_WR_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_addr = {4'h2, 4'h4};
    req_data = {7'h01, 7'h02};
    AWREADY = 1'b1; WREADY = 1'b1;
    req = 2'b01;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) req = 2'b11;
      @(negedge clk);
      if (k < 20) begin
        checks++;
        if (err !== 2'b00 || BREADY !== 1'b1) begin
          errors++;
          $display("FAIL timeout_wait_k%0d: got err=%b bready=%b expected 00 1", k, err, BREADY);
        end
      end else begin
        checks++;
        if ({err, BREADY, gnt, done} !== 7'b0100000) begin
          errors++;
          $display("FAIL timeout_err: got err=%b bready=%b gnt=%b done=%b expected 01 0 00 00",
                   err, BREADY, gnt, done);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({gnt, err} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_next: got gnt=%b err=%b expected 10 00", gnt, err);
    end
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_split_handshake();
    test_early_bvalid();
    test_reset_mid_resp();
`ifdef AUD_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
